// File: rtl/sem_pkg.sv
// Shared state encodings and light codes for the traffic-light sequencer.
package sem_pkg;

  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_YELLOW = 2'd1,
    ST_GREEN  = 2'd2,
    ST_GY     = 2'd3
  } sem_state_e;

  localparam logic [1:0] CODE_RED   = 2'b00;
  localparam logic [1:0] CODE_YEL   = 2'b01;
  localparam logic [1:0] CODE_GREEN = 2'b11;
  localparam logic [1:0] CODE_GY    = 2'b10;

  // Light-decoder code for a given state.
  function automatic logic [1:0] state_code(input sem_state_e s);
    logic [1:0] code;
    code = CODE_RED;
    unique case (s)
      ST_RED:    code = CODE_RED;
      ST_YELLOW: code = CODE_YEL;
      ST_GREEN:  code = CODE_GREEN;
      ST_GY:     code = CODE_GY;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/semafor_seq_if.sv
// Control/status bundle between the light sequencer and its surroundings.
interface semafor_seq_if;
  logic       force_red;
  logic       ped_req;
  logic       ped_ack;
  logic       contr1;
  logic       contr0;
  logic [1:0] phase;

  modport master (output force_red, ped_req, input ped_ack, contr1, contr0, phase);
  modport slave  (input force_red, ped_req, output ped_ack, contr1, contr0, phase);
endinterface

// File: rtl/sem_tick_gen.sv
// Free-running prescaler; tick is high for the cycle in which the count sits at CLK_DIV-1.
module sem_tick_gen #(
  parameter int unsigned CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
  end

  // tick_q is registered from the next count so it aligns with cnt_q == LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= (cnt_d == LAST);
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/semafor_seq.sv
// Timed RED/YELLOW/GREEN/GREEN_YELLOW sequencer with forced red.
// Optional pedestrian request/acknowledge when PED_REQ_EN is defined.
module semafor_seq #(
  parameter int unsigned CLK_DIV     = 50_000_000,
  parameter int unsigned T_RED       = 10,
  parameter int unsigned T_YEL       = 2,
  parameter int unsigned T_GREEN     = 10,
  parameter int unsigned T_GREEN_MIN = 4,
  parameter int unsigned T_GY        = 2
) (
  input  logic         clk,
  input  logic         rst,
  semafor_seq_if.slave sif
);

  import sem_pkg::*;

  localparam int unsigned T_MAX_RY = (T_RED > T_YEL) ? T_RED : T_YEL;
  localparam int unsigned T_MAX_GG = (T_GREEN > T_GY) ? T_GREEN : T_GY;
  localparam int unsigned T_MAX    = (T_MAX_RY > T_MAX_GG) ? T_MAX_RY : T_MAX_GG;
  localparam int unsigned CNT_W    = $clog2(T_MAX + 1);

  sem_state_e       state_q, state_d;
  logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [1:0]       code_q, phase_q;
  logic             tick;
  logic             ped_cut;

  sem_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next-state and phase counter; everything moves only on tick.
  always_comb begin
    state_d     = state_q;
    phase_cnt_d = phase_cnt_q;
    if (tick) begin
      phase_cnt_d = phase_cnt_q + CNT_W'(1);
      unique case (state_q)
        ST_RED: begin
          if (phase_cnt_q == CNT_W'(T_RED - 1)) begin
            if (sif.force_red) begin
              phase_cnt_d = phase_cnt_q;
            end else begin
              state_d     = ST_YELLOW;
              phase_cnt_d = '0;
            end
          end
        end
        ST_YELLOW: begin
          if (phase_cnt_q == CNT_W'(T_YEL - 1)) begin
            state_d     = sif.force_red ? ST_RED : ST_GREEN;
            phase_cnt_d = '0;
          end
        end
        ST_GREEN: begin
          if ((phase_cnt_q == CNT_W'(T_GREEN - 1)) || sif.force_red || ped_cut) begin
            state_d     = ST_GY;
            phase_cnt_d = '0;
          end
        end
        ST_GY: begin
          if (phase_cnt_q == CNT_W'(T_GY - 1)) begin
            state_d     = ST_RED;
            phase_cnt_d = '0;
          end
        end
      endcase
    end
  end

  // Outputs are registered from the next state so the code tracks the state with no lag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RED;
      phase_cnt_q <= '0;
      code_q      <= CODE_RED;
      phase_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      phase_cnt_q <= phase_cnt_d;
      code_q      <= state_code(state_d);
      phase_q     <= 2'(state_d);
    end
  end

  assign sif.contr1 = code_q[1];
  assign sif.contr0 = code_q[0];
  assign sif.phase  = phase_q;

`ifdef PED_REQ_EN
  logic ped_q, ped_d, ped_ack_q, ped_ack_d, enter_red;

  assign ped_cut = ped_q && (phase_cnt_q >= CNT_W'(T_GREEN_MIN - 1));

  // A new request on the serving edge wins over the clear.
  always_comb begin
    enter_red = (state_d == ST_RED) && (state_q != ST_RED);
    ped_ack_d = enter_red && ped_q;
    ped_d     = sif.ped_req | (ped_q & ~enter_red);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ped_q     <= 1'b0;
      ped_ack_q <= 1'b0;
    end else begin
      ped_q     <= ped_d;
      ped_ack_q <= ped_ack_d;
    end
  end

  assign sif.ped_ack = ped_ack_q;
`else
  logic unused_ped;

  assign ped_cut     = 1'b0;
  assign sif.ped_ack = 1'b0;
  assign unused_ped  = sif.ped_req & (T_GREEN_MIN != 0);
`endif

endmodule

// File: tb/tb_semafor_seq.sv
// Directed bench for semafor_seq with a 4-clock tick; builds with or without PED_REQ_EN.
module tb_semafor_seq;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

`ifdef PED_REQ_EN
  localparam int   GREEN_PED_LEN = 8;
  localparam logic ACK_EXP       = 1'b1;
`else
  localparam int   GREEN_PED_LEN = 16;
  localparam logic ACK_EXP       = 1'b0;
`endif

  semafor_seq_if sif ();

  semafor_seq #(
    .CLK_DIV    (4),
    .T_RED      (3),
    .T_YEL      (1),
    .T_GREEN    (4),
    .T_GREEN_MIN(2),
    .T_GY       (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .sif (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Assert reset for a few cycles and release it on a falling edge.
  task automatic do_reset(input logic force_lvl);
    rst           = 1'b1;
    sif.force_red = force_lvl;
    sif.ped_req   = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  // Length in cycles of the run of the current light code, bounded by max_len.
  task automatic measure(output logic [1:0] code, output int len, input int max_len);
    code = {sif.contr1, sif.contr0};
    len  = 0;
    while (({sif.contr1, sif.contr0} === code) && (len < max_len)) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst           = 1'b1;
    sif.force_red = 1'b0;
    sif.ped_req   = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({sif.contr1, sif.contr0} !== 2'b00) begin
      errors++;
      $display("FAIL reset_code: got %b expected 00", {sif.contr1, sif.contr0});
    end
    checks++;
    if (sif.phase !== 2'd0) begin
      errors++;
      $display("FAIL reset_phase: got %0d expected 0", sif.phase);
    end
    checks++;
    if (sif.ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_ack: got %b expected 0", sif.ped_ack);
    end
    sif.ped_req = 1'b0;
  endtask

  task automatic test_cycle();
    logic [1:0] c;
    int         n;
    logic [1:0] exp_code [5] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] exp_phase[5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    int         exp_len  [5] = '{12, 4, 16, 4, 12};
    do_reset(1'b0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (sif.phase !== exp_phase[i]) begin
        errors++;
        $display("FAIL cycle_phase[%0d]: got %0d expected %0d", i, sif.phase, exp_phase[i]);
      end
      measure(c, n, 100);
      checks++;
      if (c !== exp_code[i] || n !== exp_len[i]) begin
        errors++;
        $display("FAIL cycle_run[%0d]: got code %b len %0d expected code %b len %0d",
                 i, c, n, exp_code[i], exp_len[i]);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] c;
    int         n;
    do_reset(1'b0);
    measure(c, n, 100);
    measure(c, n, 100);
    repeat (5) @(negedge clk);
    checks++;
    if ({sif.contr1, sif.contr0} !== 2'b11) begin
      errors++;
      $display("FAIL arst_pre_green: got %b expected 11", {sif.contr1, sif.contr0});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({sif.contr1, sif.contr0} !== 2'b00 || sif.phase !== 2'd0) begin
      errors++;
      $display("FAIL arst_immediate: got code %b phase %0d expected code 00 phase 0",
               {sif.contr1, sif.contr0}, sif.phase);
    end
    @(negedge clk);
    rst = 1'b0;
    measure(c, n, 100);
    checks++;
    if (c !== 2'b00 || n !== 12) begin
      errors++;
      $display("FAIL arst_red_len: got code %b len %0d expected code 00 len 12", c, n);
    end
  endtask

  task automatic test_force_red_hold();
    int bad;
    do_reset(1'b1);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if ({sif.contr1, sif.contr0} !== 2'b00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL force_hold: got %0d non-red cycles expected 0", bad);
    end
    sif.force_red = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({sif.contr1, sif.contr0} !== 2'b00) begin
      errors++;
      $display("FAIL force_release_early: got %b expected 00", {sif.contr1, sif.contr0});
    end
    @(negedge clk);
    checks++;
    if ({sif.contr1, sif.contr0} !== 2'b01) begin
      errors++;
      $display("FAIL force_release_tick: got %b expected 01", {sif.contr1, sif.contr0});
    end
  endtask

  task automatic test_force_red_green();
    logic [1:0] c;
    int         n;
    do_reset(1'b0);
    measure(c, n, 100);
    measure(c, n, 100);
    sif.force_red = 1'b1;
    measure(c, n, 100);
    checks++;
    if (c !== 2'b11 || n !== 4) begin
      errors++;
      $display("FAIL force_green_cut: got code %b len %0d expected code 11 len 4", c, n);
    end
    measure(c, n, 100);
    checks++;
    if (c !== 2'b10 || n !== 4) begin
      errors++;
      $display("FAIL force_gy_len: got code %b len %0d expected code 10 len 4", c, n);
    end
    measure(c, n, 40);
    checks++;
    if (c !== 2'b00 || n !== 40) begin
      errors++;
      $display("FAIL force_red_held: got code %b len %0d expected code 00 len 40", c, n);
    end
    sif.force_red = 1'b0;
  endtask

  task automatic test_ped_pulse();
    logic [1:0] c;
    int         n;
    do_reset(1'b0);
    measure(c, n, 100);
    measure(c, n, 100);
    sif.ped_req = 1'b1;
    @(negedge clk);
    sif.ped_req = 1'b0;
    measure(c, n, 100);
    checks++;
    if (c !== 2'b11 || n + 1 !== GREEN_PED_LEN) begin
      errors++;
      $display("FAIL ped_green_len: got code %b len %0d expected code 11 len %0d",
               c, n + 1, GREEN_PED_LEN);
    end
    measure(c, n, 100);
    checks++;
    if (sif.ped_ack !== ACK_EXP || {sif.contr1, sif.contr0} !== 2'b00) begin
      errors++;
      $display("FAIL ped_ack_entry: got ack %b code %b expected ack %b code 00",
               sif.ped_ack, {sif.contr1, sif.contr0}, ACK_EXP);
    end
    @(negedge clk);
    checks++;
    if (sif.ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL ped_ack_width: got %b expected 0", sif.ped_ack);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] c;
    int         n;
    do_reset(1'b0);
    measure(c, n, 100);
    measure(c, n, 100);
    measure(c, n, 100);
    checks++;
    if (c !== 2'b11 || n !== 16) begin
      errors++;
      $display("FAIL b2b_first_green: got code %b len %0d expected code 11 len 16", c, n);
    end
    sif.ped_req = 1'b1;
    measure(c, n, 100);
    checks++;
    if (sif.ped_ack !== ACK_EXP) begin
      errors++;
      $display("FAIL b2b_ack_entry: got %b expected %b", sif.ped_ack, ACK_EXP);
    end
    sif.ped_req = 1'b0;
    @(negedge clk);
    checks++;
    if (sif.ped_ack !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_width: got %b expected 0", sif.ped_ack);
    end
    measure(c, n, 100);
    checks++;
    if (c !== 2'b00 || n + 1 !== 12) begin
      errors++;
      $display("FAIL b2b_red_len: got code %b len %0d expected code 00 len 12", c, n + 1);
    end
    measure(c, n, 100);
    measure(c, n, 100);
    checks++;
    if (c !== 2'b11 || n !== GREEN_PED_LEN) begin
      errors++;
      $display("FAIL b2b_second_green: got code %b len %0d expected code 11 len %0d",
               c, n, GREEN_PED_LEN);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    sif.force_red = 1'b0;
    sif.ped_req   = 1'b0;
    test_reset();
    test_cycle();
    test_async_reset();
    test_force_red_hold();
    test_force_red_green();
    test_ped_pulse();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
